// File: rtl/ixc_assign_sched.sv
// Round-robin scheduler sharing one WIDTH-bit transfer path between NREQ requesters.
// Define IXC_ASSIGN_SCHED_LOCK_EN to hold the path for multi-beat bursts ended by 'last'.
module ixc_assign_sched #(
    parameter int WIDTH = 83,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic [NREQ-1:0]       last,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      L,
    output logic                  l_valid,
    input  logic                  l_ready,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_L;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   w_eligible;
    logic [NREQ-1:0]   w_gnt;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_nextPtr;
    logic              w_found;
    logic              w_loadOk;
    logic              w_grant;
    logic              w_locked;
    int                w_cand;

`ifdef IXC_ASSIGN_SCHED_LOCK_EN
    logic              r_lockValid;
    logic [PW-1:0]     r_lockOwner;
    assign w_locked = r_lockValid;
`else
    logic              w_unusedLast;
    assign w_unusedLast = ^last;
    assign w_locked     = 1'b0;
`endif

    // Rotating priority search starting at r_ptr; a held lock narrows eligibility to its owner.
    always_comb begin
        w_eligible = req;
`ifdef IXC_ASSIGN_SCHED_LOCK_EN
        if (r_lockValid) begin
            w_eligible = req & (NREQ'(1) << r_lockOwner);
        end
`endif
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = 0;
        for (int off = 0; off < NREQ; off++) begin
            w_cand = (int'(r_ptr) + off) % NREQ;
            if (!w_found && w_eligible[w_cand]) begin
                w_found = 1'b1;
                w_idx   = PW'(w_cand);
            end
        end
        w_loadOk = (r_state == EMPTY) || l_ready;
        w_gnt    = '0;
        if (!rst && w_loadOk && w_found) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign w_grant   = |w_gnt;
    assign w_nextPtr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_L     <= '0;
            r_ptr   <= '0;
`ifdef IXC_ASSIGN_SCHED_LOCK_EN
            r_lockValid <= 1'b0;
            r_lockOwner <= '0;
`endif
        end else if (w_grant) begin
            r_state <= FULL;
            r_L     <= data[w_idx*WIDTH +: WIDTH];
`ifdef IXC_ASSIGN_SCHED_LOCK_EN
            // Pointer stays frozen through a burst and advances past the owner on its final beat.
            r_lockValid <= !last[w_idx];
            r_lockOwner <= w_idx;
            if (last[w_idx]) begin
                r_ptr <= w_nextPtr;
            end
`else
            r_ptr <= w_nextPtr;
`endif
        end else if (r_state == FULL && l_ready) begin
            r_state <= EMPTY;
        end
    end

    assign gnt     = w_gnt;
    assign L       = r_L;
    assign l_valid = (r_state == FULL);
    assign busy    = !rst && ((r_state == FULL) || (|req) || w_locked);

endmodule

// File: tb/tb_ixc_assign_sched.sv
// Directed self-checking bench for ixc_assign_sched (WIDTH=83, NREQ=4).
// Burst expectations follow IXC_ASSIGN_SCHED_LOCK_EN when it is defined.
module tb_ixc_assign_sched;

    localparam int WIDTH = 83;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       last;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      L;
    logic                  l_valid;
    logic                  l_ready;
    logic                  busy;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] bigVec;
    logic [NREQ-1:0]  burstGnt [4];
    logic [WIDTH-1:0] burstL   [4];

    ixc_assign_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .last    (last),
        .gnt     (gnt),
        .L       (L),
        .l_valid (l_valid),
        .l_ready (l_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive request-side inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lst,
                                 input logic rdy);
        req     = r;
        last    = lst;
        l_ready = rdy;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setData(input int idx, input logic [WIDTH-1:0] v);
        data[idx*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bigVec      = 83'h4_1234_5678_9ABC_DEF0_1234;
        data        = '0;
        for (int i = 0; i < NREQ; i++) setData(i, WIDTH'(i + 1));

        // Reset held two cycles with every requester asking.
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("rst_gnt0", gnt, 0);
        checkOutput("rst_busy0", busy, 0);
        checkOutput("rst_L0", L, 0);
        checkOutput("rst_valid0", l_valid, 0);
        stepCycle();
        checkOutput("rst_gnt1", gnt, 0);
        checkOutput("rst_busy1", busy, 0);
        checkOutput("rst_L1", L, 0);
        checkOutput("rst_valid1", l_valid, 0);
        rst = 1'b0;
        #1;

        // Round-robin with all requesters: gnt 0,1,2,3,0 and L trails by one cycle.
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_gnt%0d", i), gnt, 128'(4'b0001 << (i % 4)));
            if (i > 0) begin
                checkOutput($sformatf("rr_L%0d", i), L, 128'(((i - 1) % 4) + 1));
                checkOutput($sformatf("rr_valid%0d", i), l_valid, 1);
            end
            stepCycle();
        end
        checkOutput("rr_L5", L, 1);

        // Backpressure: load 5 from requester 1, then stall three cycles.
        setData(1, WIDTH'(5));
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("bp_load_gnt", gnt, 4'b0010);
        stepCycle();
        setData(1, bigVec);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_gnt%0d", k), gnt, 0);
            checkOutput($sformatf("bp_L%0d", k), L, 5);
            checkOutput($sformatf("bp_valid%0d", k), l_valid, 1);
            stepCycle();
        end
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("bp_release_gnt", gnt, 4'b0010);
        stepCycle();
        checkOutput("bp_release_L", L, 128'(bigVec));

        // Drain to empty with no requests: L is kept, l_valid and busy drop.
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("drain_gnt", gnt, 0);
        checkOutput("drain_valid_before", l_valid, 1);
        stepCycle();
        checkOutput("drain_valid_after", l_valid, 0);
        checkOutput("drain_L", L, 128'(bigVec));
        checkOutput("drain_busy", busy, 0);

        // Wrap: move pointer to 3 via a grant to 2, then req 3 and 0 alternate.
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        checkOutput("wrap_pre_gnt", gnt, 4'b0100);
        stepCycle();
        applyStimulus(4'b1001, 4'b0000, 1'b1);
        checkOutput("wrap_gnt3", gnt, 4'b1000);
        stepCycle();
        checkOutput("wrap_L4", L, 4);
        checkOutput("wrap_gnt0", gnt, 4'b0001);
        stepCycle();
        checkOutput("wrap_L1", L, 1);
        checkOutput("wrap_gnt3_again", gnt, 4'b1000);
        stepCycle();

        // Burst from requester 0 (last=0,0,1) competing with requester 1; pointer is at 0.
`ifdef IXC_ASSIGN_SCHED_LOCK_EN
        burstGnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        burstL   = '{83'h1, 83'h1, 83'h1, bigVec};
`else
        burstGnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        burstL   = '{83'h1, bigVec, 83'h1, bigVec};
`endif
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0011, (b < 2) ? 4'b0010 : 4'b0011, 1'b1);
            checkOutput($sformatf("burst_gnt%0d", b), gnt, 128'(burstGnt[b]));
            stepCycle();
            checkOutput($sformatf("burst_L%0d", b), L, 128'(burstL[b]));
        end

        applyStimulus(4'b0000, 4'b0000, 1'b1);
        stepCycle();
        checkOutput("final_valid", l_valid, 0);
        checkOutput("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
